// File: rtl/signnarrow_if.sv
// Handshake bundle for the signed narrowing unit: input word stream in,
// narrowed result stream out.
interface signnarrow_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2
);
    logic [IN_W-1:0]  in;
    logic             in_valid;
    logic             in_ready;
    logic             wrap;
    logic [OUT_W-1:0] out;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in, in_valid, wrap, out_ready,
        input  in_ready, out, out_ovf, out_valid
    );

    modport slave (
        input  in, in_valid, wrap, out_ready,
        output in_ready, out, out_ovf, out_valid
    );
endinterface

// File: rtl/signnarrow.sv
// Signed narrowing unit: reduces IN_W-bit signed words to OUT_W bits by
// saturation or wrap, flags out-of-range inputs, buffers results in a
// 2-entry FIFO and counts overflow events.
module signnarrow #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    signnarrow_if.slave      bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state_q, state_d;
    logic             head_q, tail_q;
    logic [OUT_W-1:0] data_q [0:1];
    logic             ovf_q  [0:1];

    logic [IN_W-OUT_W:0] hi_bits;
    logic                ovf;
    logic [OUT_W-1:0]    nar;
    logic                push, pop;

    // Range check and narrowing of the offered word
    always_comb begin
        hi_bits = bus.in[IN_W-1:OUT_W-1];
        ovf     = !((&hi_bits) || !(|hi_bits));
        nar     = bus.in[OUT_W-1:0];
        if (ovf && !bus.wrap) begin
            nar = bus.in[IN_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Handshake qualifiers and head-entry output drive
    always_comb begin
        bus.out_valid = (state_q != EMPTY);
        bus.in_ready  = (state_q != FULL) || bus.out_ready;
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
        bus.out       = bus.out_valid ? data_q[head_q] : '0;
        bus.out_ovf   = bus.out_valid ? ovf_q[head_q] : 1'b0;
    end

    // Occupancy next state; simultaneous push and pop leaves it unchanged
    always_comb begin
        state_d = state_q;
        case ({push, pop})
            2'b10:   state_d = (state_q == EMPTY) ? ONE : FULL;
            2'b01:   state_d = (state_q == FULL) ? ONE : EMPTY;
            default: state_d = state_q;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Queue storage and head/tail pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                ovf_q[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                data_q[tail_q] <= nar;
                ovf_q[tail_q]  <= ovf;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    // Saturating overflow event counter; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (cnt_clr) begin
            ovf_count <= '0;
        end else if (push && ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_signnarrow.sv
// Self-checking bench for signnarrow: directed test-plan steps followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_signnarrow;
    localparam int IN_W  = 8;
    localparam int OUT_W = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [OUT_W-1:0] v;
        logic             o;
    } ent_t;

    logic             clk;
    logic             rst;
    logic             cnt_clr;
    logic [CNT_W-1:0] ovf_count;

    signnarrow_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bif ();

    signnarrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif.slave),
        .cnt_clr   (cnt_clr),
        .ovf_count (ovf_count)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    int   mcnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference narrowing from signed integer arithmetic
    function automatic logic [OUT_W-1:0] ref_nar(input logic [IN_W-1:0] x, input bit wr, output bit o);
        int v, mx, mn, m, r;
        v  = int'($signed(x));
        mx = (1 << (OUT_W - 1)) - 1;
        mn = -(1 << (OUT_W - 1));
        m  = 1 << OUT_W;
        o  = (v > mx) || (v < mn);
        r  = v;
        if (!wr && v > mx) r = mx;
        if (!wr && v < mn) r = mn;
        r = ((r % m) + m) % m;
        return r[OUT_W-1:0];
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, bif.out_valid, q.size() != 0);
        chk({tag, ".out"}, bif.out, (q.size() != 0) ? q[0].v : '0);
        chk({tag, ".out_ovf"}, bif.out_ovf, (q.size() != 0) ? q[0].o : 1'b0);
        chk({tag, ".ovf_count"}, ovf_count, mcnt);
    endtask

    // One clock cycle of traffic, entered and left at a falling edge
    task automatic step(input string tag, input bit v, input logic [IN_W-1:0] d,
                        input bit w, input bit ordy, input bit clr);
        bit               acc, pop, o, rdy;
        logic [OUT_W-1:0] r;
        bif.in_valid  = v;
        bif.in        = d;
        bif.wrap      = w;
        bif.out_ready = ordy;
        cnt_clr       = clr;
        #1;
        rdy = (q.size() < 2) || ordy;
        chk({tag, ".in_ready"}, bif.in_ready, rdy);
        acc = v && rdy;
        pop = (q.size() != 0) && ordy;
        r   = ref_nar(d, w, o);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(ent_t'({r, o}));
        if (clr) mcnt = 0;
        else if (acc && o && mcnt < CMAX) mcnt++;
        @(negedge clk);
        check_outputs(tag);
    endtask

    logic [IN_W-1:0] sweep [7] = '{8'h01, 8'h00, 8'hFF, 8'hFE, 8'h05, 8'h80, 8'h7F};
    logic [IN_W-1:0] wvec  [4] = '{8'h05, 8'hFD, 8'h02, 8'hFF};

    initial begin
        rst           = 1'b1;
        cnt_clr       = 1'b0;
        bif.in        = '0;
        bif.in_valid  = 1'b0;
        bif.wrap      = 1'b0;
        bif.out_ready = 1'b0;
        #2;
        chk("reset.in_ready", bif.in_ready, 1'b1);
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Saturate sweep with out_ready high: one word per cycle
        for (int i = 0; i < 7; i++) step("sat", 1'b1, sweep[i], 1'b0, 1'b1, 1'b0);
        step("sat_drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("sat.ovf_count_3", ovf_count, 3);

        // Wrap mode
        for (int i = 0; i < 4; i++) step("wrap", 1'b1, wvec[i], 1'b1, 1'b1, 1'b0);
        step("wrap_drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Backpressure: third offer is refused until a pop
        step("bp", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step("bp", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        step("bp_full", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bp.head_01", bif.out, 2'b01);
        // Full queue with push and pop together
        step("fullpp", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step("fullpp", 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
        step("drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step("drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step("drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Counter saturation and clear priority
        step("cclr", 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) step("csat", 1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
        chk("cnt.sat_255", ovf_count, 255);
        step("cnt_clr_ovf", 1'b1, 8'h90, 1'b0, 1'b1, 1'b1);
        chk("cnt.clr_0", ovf_count, 0);

        // Asynchronous clear with two entries queued
        step("pre_rst", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        bif.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        q.delete();
        mcnt = 0;
        chk("arst.in_ready", bif.in_ready, 1'b1);
        check_outputs("arst");
        #2;
        rst = 1'b0;
        @(negedge clk);
        step("post_rst", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("post_rst.out_01", bif.out, 2'b01);
        step("post_rst_drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [IN_W-1:0] d;
            if ($urandom_range(0, 1) == 0) d = IN_W'($urandom_range(0, 255));
            else d = IN_W'($urandom_range(0, 3) - 2);
            step("rand", $urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
